// File: rtl/lif_neuron_array.sv
// lif_neuron_array: time-multiplexed array of leaky integrate-and-fire neurons.
// One shared subtract/multiply/add datapath updates one neuron per cycle. A sweep
// over all neurons is one simulation time step.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   step_start_i      request one update sweep (ignored while busy)
//   currents_i        per-neuron signed input current, neuron k at [k*W +: W]
//   step_busy_o       sweep in progress
//   step_done_o       one-cycle pulse when the sweep finishes
//   spike_valid_o     one-cycle pulse per emitted spike, spike_id_o names the neuron
//   cfg_*_i           per-neuron parameter write port
//                     (sel 0 E_l, 1 tau_mem, 2 v_thresh, 3 tau_ref, 4 v_reset)
//   rd_addr_i         membrane readback address; rd_vmem_o is registered
module lif_neuron_array #(
    parameter int unsigned NUM_NEURONS = 8,
    parameter int unsigned WORD_WIDTH  = 16,
    parameter int unsigned DECAY_SHIFT = 15,
    parameter int unsigned REF_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              step_start_i,
    input  logic [NUM_NEURONS*WORD_WIDTH-1:0] currents_i,
    output logic                              step_busy_o,
    output logic                              step_done_o,
    output logic                              spike_valid_o,
    output logic [$clog2(NUM_NEURONS)-1:0]    spike_id_o,
    input  logic                              cfg_we_i,
    input  logic [$clog2(NUM_NEURONS)-1:0]    cfg_addr_i,
    input  logic [2:0]                        cfg_sel_i,
    input  logic [WORD_WIDTH-1:0]             cfg_wdata_i,
    input  logic [$clog2(NUM_NEURONS)-1:0]    rd_addr_i,
    output logic [WORD_WIDTH-1:0]             rd_vmem_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_NEURONS);
    localparam int unsigned W      = WORD_WIDTH;
    localparam int unsigned DIFF_W = W + 1;
    localparam int unsigned PROD_W = 2 * DIFF_W;
    localparam int unsigned SUM_W  = PROD_W + 1;

    localparam logic signed [W-1:0] V_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] V_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             capture_c;

    // Per-neuron state and parameters
    logic signed [W-1:0]   vmem_q   [NUM_NEURONS];
    logic [REF_WIDTH-1:0]  ref_cnt_q[NUM_NEURONS];
    logic signed [W-1:0]   e_l_q    [NUM_NEURONS];
    logic [W-1:0]          tau_mem_q[NUM_NEURONS];
    logic signed [W-1:0]   thresh_q [NUM_NEURONS];
    logic [REF_WIDTH-1:0]  tau_ref_q[NUM_NEURONS];
    logic signed [W-1:0]   vreset_q [NUM_NEURONS];

    logic [NUM_NEURONS*W-1:0] cur_q;

    logic                 busy_q, done_q, spike_valid_q;
    logic [IDX_W-1:0]     spike_id_q;
    logic [W-1:0]         rd_vmem_q;

    // Operands of the neuron currently addressed by idx_q
    logic signed [W-1:0]      v_cur, e_l_cur, thresh_cur, vreset_cur, i_cur;
    logic [W-1:0]             tau_cur;
    logic [REF_WIDTH-1:0]     ref_cur, tau_ref_cur;
    logic signed [DIFF_W-1:0] diff_c, tau_s_c;
    logic signed [PROD_W-1:0] prod_c, leak_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic signed [W-1:0]      v_new_c;
    logic                     upd_c, ref_active_c, fire_c;
    logic [W-1:0]             rd_sel_c;

    // Operand select for the shared datapath
    always_comb begin
        v_cur       = '0;
        e_l_cur     = '0;
        thresh_cur  = '0;
        vreset_cur  = '0;
        i_cur       = '0;
        tau_cur     = '0;
        ref_cur     = '0;
        tau_ref_cur = '0;
        for (int i = 0; i < int'(NUM_NEURONS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                v_cur       = vmem_q[i];
                e_l_cur     = e_l_q[i];
                thresh_cur  = thresh_q[i];
                vreset_cur  = vreset_q[i];
                i_cur       = cur_q[i*W +: W];
                tau_cur     = tau_mem_q[i];
                ref_cur     = ref_cnt_q[i];
                tau_ref_cur = tau_ref_q[i];
            end
        end
    end

    // Leak, integrate and saturate at full precision
    always_comb begin
        diff_c  = DIFF_W'(e_l_cur) - DIFF_W'(v_cur);
        tau_s_c = $signed({1'b0, tau_cur});
        prod_c  = PROD_W'(diff_c) * PROD_W'(tau_s_c);
        leak_c  = prod_c >>> DECAY_SHIFT;
        sum_c   = SUM_W'(v_cur) + SUM_W'(leak_c) + SUM_W'(i_cur);
        if (sum_c > SUM_W'(V_MAX)) begin
            v_new_c = V_MAX;
        end else if (sum_c < SUM_W'(V_MIN)) begin
            v_new_c = V_MIN;
        end else begin
            v_new_c = sum_c[W-1:0];
        end
        upd_c        = (state_q == S_UPDATE);
        ref_active_c = (ref_cur != '0);
        fire_c       = upd_c && !ref_active_c && (v_new_c >= thresh_cur);
    end

    // Sweep sequencing
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        capture_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (step_start_i) begin
                    state_d   = S_UPDATE;
                    idx_d     = '0;
                    capture_c = 1'b1;
                end
            end
            S_UPDATE: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Readback mux; out-of-range addresses read zero
    always_comb begin
        rd_sel_c = '0;
        for (int i = 0; i < int'(NUM_NEURONS); i++) begin
            if (rd_addr_i == IDX_W'(i)) rd_sel_c = vmem_q[i];
        end
    end

    // FSM state, status outputs and current shadow
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_id_q    <= '0;
            rd_vmem_q     <= '0;
            cur_q         <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            busy_q        <= (state_d != S_IDLE);
            done_q        <= (state_d == S_DONE);
            spike_valid_q <= fire_c;
            spike_id_q    <= fire_c ? idx_q : '0;
            rd_vmem_q     <= rd_sel_c;
            if (capture_c) cur_q <= currents_i;
        end
    end

    // Membrane and refractory update of the addressed neuron
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                vmem_q[i]    <= '0;
                ref_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                if (upd_c && idx_q == IDX_W'(i)) begin
                    if (ref_active_c) begin
                        vmem_q[i]    <= vreset_cur;
                        ref_cnt_q[i] <= ref_cur - REF_WIDTH'(1);
                    end else if (fire_c) begin
                        vmem_q[i]    <= vreset_cur;
                        ref_cnt_q[i] <= tau_ref_cur;
                    end else begin
                        vmem_q[i]    <= v_new_c;
                    end
                end
            end
        end
    end

    // Parameter writes; the update in the same cycle still sees the old value
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                e_l_q[i]     <= '0;
                tau_mem_q[i] <= '0;
                thresh_q[i]  <= V_MAX;
                tau_ref_q[i] <= '0;
                vreset_q[i]  <= '0;
            end
        end else if (cfg_we_i) begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                if (cfg_addr_i == IDX_W'(i)) begin
                    case (cfg_sel_i)
                        3'd0:    e_l_q[i]     <= cfg_wdata_i;
                        3'd1:    tau_mem_q[i] <= cfg_wdata_i;
                        3'd2:    thresh_q[i]  <= cfg_wdata_i;
                        3'd3:    tau_ref_q[i] <= REF_WIDTH'(cfg_wdata_i);
                        3'd4:    vreset_q[i]  <= cfg_wdata_i;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign step_busy_o   = busy_q;
    assign step_done_o   = done_q;
    assign spike_valid_o = spike_valid_q;
    assign spike_id_o    = spike_id_q;
    assign rd_vmem_o     = rd_vmem_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: directed checks of leak, threshold/refractory, saturation,
// sweep timing, mid-sweep start/reset and config collision with hand-computed values.
module tb_lif_neuron_array;

    localparam int N = 8;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             step_start_i;
    logic [N*W-1:0]   currents_i;
    logic             step_busy_o, step_done_o, spike_valid_o;
    logic [2:0]       spike_id_o;
    logic             cfg_we_i;
    logic [2:0]       cfg_addr_i;
    logic [2:0]       cfg_sel_i;
    logic [W-1:0]     cfg_wdata_i;
    logic [2:0]       rd_addr_i;
    logic [W-1:0]     rd_vmem_o;

    lif_neuron_array dut (
        .clk           (clk),
        .reset         (reset),
        .step_start_i  (step_start_i),
        .currents_i    (currents_i),
        .step_busy_o   (step_busy_o),
        .step_done_o   (step_done_o),
        .spike_valid_o (spike_valid_o),
        .spike_id_o    (spike_id_o),
        .cfg_we_i      (cfg_we_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_sel_i     (cfg_sel_i),
        .cfg_wdata_i   (cfg_wdata_i),
        .rd_addr_i     (rd_addr_i),
        .rd_vmem_o     (rd_vmem_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Per-cycle observations of the last sweep, index c = cycle t0+c
    int busy_rec [N+4];
    int valid_rec[N+4];
    int id_rec   [N+4];
    int done_rec [N+4];
    int rd_rec   [N+4];

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_cur(input int k, input int val);
        currents_i[k*W +: W] = W'(val);
    endtask

    task automatic cfg_write(input int addr, input int sel, input int data);
        @(negedge clk);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = 3'(addr);
        cfg_sel_i   = 3'(sel);
        cfg_wdata_i = W'(data);
        @(negedge clk);
        cfg_we_i    = 1'b0;
    endtask

    task automatic read_v(input int a, output int v);
        @(negedge clk);
        rd_addr_i = 3'(a);
        @(negedge clk);
        v = int'($signed(rd_vmem_o));
    endtask

    // act: 0 none, 1 re-assert step_start, 2 reset, 3 write v_thresh[3]=100; applied in cycle t0+act_cyc
    task automatic run_step(input int act_cyc, input int act);
        @(negedge clk);
        step_start_i = 1'b1;
        @(posedge clk);
        #1 step_start_i = 1'b0;
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            busy_rec[c]  = int'(step_busy_o);
            valid_rec[c] = int'(spike_valid_o);
            id_rec[c]    = int'(spike_id_o);
            done_rec[c]  = int'(step_done_o);
            rd_rec[c]    = int'($signed(rd_vmem_o));
            if (c == act_cyc) begin
                case (act)
                    1: step_start_i = 1'b1;
                    2: reset = 1'b1;
                    3: begin
                        cfg_we_i    = 1'b1;
                        cfg_addr_i  = 3'd3;
                        cfg_sel_i   = 3'd2;
                        cfg_wdata_i = W'(100);
                    end
                    default: ;
                endcase
            end else if (c == act_cyc + 1) begin
                step_start_i = 1'b0;
                reset        = 1'b0;
                cfg_we_i     = 1'b0;
            end
        end
    endtask

    // Expected spiking neurons ka, kb (-1 = none); neuron k spikes in cycle t0+2+k
    task automatic check_spikes(input string tag, input int ka, input int kb);
        int n = 0;
        int n_exp = 0;
        for (int c = 1; c <= N + 3; c++) n += valid_rec[c];
        if (ka >= 0) n_exp++;
        if (kb >= 0) n_exp++;
        check_eq({tag, " spike_count"}, n, n_exp);
        if (ka >= 0) begin
            check_eq({tag, " spike_a_valid"}, valid_rec[ka+2], 1);
            check_eq({tag, " spike_a_id"}, id_rec[ka+2], ka);
        end
        if (kb >= 0) begin
            check_eq({tag, " spike_b_valid"}, valid_rec[kb+2], 1);
            check_eq({tag, " spike_b_id"}, id_rec[kb+2], kb);
        end
    endtask

    task automatic check_done(input string tag);
        int n = 0;
        for (int c = 1; c <= N + 3; c++) n += done_rec[c];
        check_eq({tag, " done_count"}, n, 1);
        check_eq({tag, " done_cycle"}, done_rec[N+1], 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int v;
        int exp_leak[3];
        int exp_all[N];
        int spk_b[4];

        reset        = 1'b1;
        step_start_i = 1'b0;
        currents_i   = '0;
        cfg_we_i     = 1'b0;
        cfg_addr_i   = '0;
        cfg_sel_i    = '0;
        cfg_wdata_i  = '0;
        rd_addr_i    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check_eq("rst busy", step_busy_o, 0);
        check_eq("rst done", step_done_o, 0);
        check_eq("rst spike_valid", spike_valid_o, 0);
        check_eq("rst spike_id", spike_id_o, 0);
        check_eq("rst rd_vmem", rd_vmem_o, 0);

        // Leak toward E_l=1000 with tau_mem=0.5: 500, 750, 875
        exp_leak = '{500, 750, 875};
        cfg_write(0, 0, 1000);
        cfg_write(0, 1, 16384);
        for (int s = 0; s < 3; s++) begin
            run_step(0, 0);
            check_spikes("leak", -1, -1);
            read_v(0, v);
            check_eq("leak vmem0", v, exp_leak[s]);
        end
        cfg_write(0, 1, 0);

        // Threshold 100, reset -50, refractory 2, constant I=150
        spk_b = '{1, 0, 0, 1};
        cfg_write(1, 2, 100);
        cfg_write(1, 4, -50);
        cfg_write(1, 3, 2);
        set_cur(1, 150);
        for (int s = 0; s < 4; s++) begin
            run_step(0, 0);
            check_spikes("refr", spk_b[s] ? 1 : -1, -1);
            read_v(1, v);
            check_eq("refr vmem1", v, -50);
        end
        set_cur(1, 0);

        // Saturation; thresh stays +max, so the clamped positive sum spikes and
        // v_reset=+max makes the clamp value visible on readback
        cfg_write(2, 4, 32767);
        set_cur(2, 32000);
        set_cur(3, -32000);
        run_step(0, 0);
        check_spikes("sat1", -1, -1);
        read_v(2, v);
        check_eq("sat1 vmem2", v, 32000);
        read_v(3, v);
        check_eq("sat1 vmem3", v, -32000);
        set_cur(3, -32768);
        run_step(0, 0);
        check_spikes("sat2", 2, -1);
        read_v(2, v);
        check_eq("sat2 vmem2", v, 32767);
        read_v(3, v);
        check_eq("sat2 vmem3", v, -32768);
        set_cur(2, -32767);
        set_cur(3, 32767);
        run_step(0, 0);
        check_spikes("sat3", -1, -1);
        read_v(2, v);
        check_eq("sat3 vmem2", v, 0);
        read_v(3, v);
        check_eq("sat3 vmem3", v, -1);
        set_cur(2, 0);
        set_cur(3, 0);

        // Multi-neuron sweep timing: neurons 2 and 7 above threshold
        cfg_write(2, 2, 10);
        cfg_write(2, 4, 0);
        cfg_write(7, 2, 10);
        set_cur(2, 20);
        set_cur(7, 20);
        run_step(0, 0);
        check_spikes("multi", 2, 7);
        check_done("multi");
        for (int c = 1; c <= N + 3; c++) begin
            check_eq($sformatf("multi busy c%0d", c), busy_rec[c], (c <= N + 1) ? 1 : 0);
        end
        exp_all = '{875, -50, 0, -1, 0, 0, 0, 0};
        for (int a = 0; a < N; a++) begin
            read_v(a, v);
            check_eq($sformatf("multi vmem%0d", a), v, exp_all[a]);
        end
        set_cur(2, 0);
        set_cur(7, 0);

        // step_start re-asserted mid-sweep is ignored
        run_step(3, 1);
        check_spikes("restart", -1, -1);
        check_done("restart");
        check_eq("restart busy_end", busy_rec[N+2] + busy_rec[N+3], 0);

        // Reset in cycle t0+3 aborts the sweep
        read_v(0, v);
        check_eq("prerst vmem0", v, 875);
        run_step(3, 2);
        check_eq("abort busy", busy_rec[4], 0);
        check_eq("abort valid", valid_rec[4], 0);
        check_eq("abort id", id_rec[4], 0);
        check_eq("abort rd_vmem", rd_rec[4], 0);
        begin
            int n = 0;
            for (int c = 1; c <= N + 3; c++) n += done_rec[c] + busy_rec[c] * ((c >= 4) ? 1 : 0);
            check_eq("abort no_done_busy", n, 0);
        end
        for (int a = 0; a < N; a++) begin
            read_v(a, v);
            check_eq($sformatf("abort vmem%0d", a), v, 0);
        end

        // Config collision: v_thresh[3] written during neuron 3's update
        cfg_write(3, 2, 1000);
        set_cur(3, 500);
        run_step(4, 3);
        check_spikes("collide1", -1, -1);
        read_v(3, v);
        check_eq("collide1 vmem3", v, 500);
        run_step(0, 0);
        check_spikes("collide2", 3, -1);
        read_v(3, v);
        check_eq("collide2 vmem3", v, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
